// File: rtl/edge_filter_stream.sv
// edge_filter_stream: streaming 3x3 edge detector, packed 1-bit edge map out.
// Kernels: Laplacian-8, Laplacian-4, Sobel; zero-padded borders, no row wrap.
module edge_filter_stream #(
  parameter int IMAGE_WIDTH  = 320,
  parameter int IMAGE_HEIGHT = 240,
  parameter int PIXEL_BITS   = 8,
  parameter int OUT_PACK     = 8
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic [1:0]            cfg_mode,
  input  logic [15:0]           cfg_threshold,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [PIXEL_BITS-1:0] in_pixel,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_PACK-1:0]   out_data,
  output logic                  busy,
  output logic                  frame_done,
  output logic [31:0]           edge_count
);

  localparam int W  = IMAGE_WIDTH;
  localparam int H  = IMAGE_HEIGHT;
  localparam int PB = PIXEL_BITS;
  localparam int OP = OUT_PACK;
  localparam int AW = PB + 5;
  localparam int MW = PB + 4;
  localparam int CW = (MW > 16) ? MW : 16;
  localparam int SW = $clog2(W*H + W + 2);
  localparam int XW = $clog2(W);
  localparam int YW = $clog2(H);
  localparam int PW = (OP > 1) ? $clog2(OP) : 1;

  localparam logic [SW-1:0] RUN_LAST = SW'(W*H - 1);
  localparam logic [SW-1:0] FL_LAST  = SW'(W*H + W);
  localparam logic [SW-1:0] SKIP     = SW'(W + 1);
  localparam logic [XW-1:0] X_LAST   = XW'(W - 1);
  localparam logic [YW-1:0] Y_LAST   = YW'(H - 1);
  localparam logic [PW-1:0] P_LAST   = PW'(OP - 1);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DRAIN} state_t;
  typedef logic signed [AW-1:0] sval_t;

  state_t          state, state_nx;
  logic [1:0]      mode_q;
  logic [15:0]     thr_q;
  logic [SW-1:0]   nstep;
  logic [XW-1:0]   icol, ccol;
  logic [YW-1:0]   crow;
  logic [PW-1:0]   pcnt;
  logic [OP-1:0]   pk, pk_nx, word;
  logic [OP:0]     pk_sh;
  logic [PB-1:0]   win [3][3];
  logic [PB-1:0]   nb  [3][3];
  logic [PB-1:0]   lb0 [W];
  logic [PB-1:0]   lb1 [W];
  logic [PB-1:0]   pin;
  sval_t           v   [3][3];
  sval_t           lap8, lap4, gx, gy;
  logic [MW-1:0]   mag;
  logic            can_step, step, produce, last, load, ebit;

  function automatic logic [MW-1:0] absv(sval_t x);
    sval_t n;
    n = x[AW-1] ? -x : x;
    return n[MW-1:0];
  endfunction

  assign can_step = !out_valid || out_ready;
  assign in_ready = (state == RUN) && can_step;
  assign busy     = (state != IDLE);
  assign step     = ((state == RUN) && in_valid && can_step)
                 || ((state == FLUSH) && can_step);
  assign pin      = (state == RUN) ? in_pixel : '0;
  assign produce  = step && (nstep >= SKIP);
  assign last     = (state == FLUSH) && (nstep == FL_LAST);
  assign load     = produce && ((pcnt == P_LAST) || last);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (start) state_nx = RUN;
      RUN:   if (step && nstep == RUN_LAST) state_nx = FLUSH;
      FLUSH: if (step && last) state_nx = DRAIN;
      DRAIN: if (out_valid && out_ready) state_nx = IDLE;
    endcase
  end

  // Window as it will be after this step; centre column picks the masks.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      nb[i][0] = win[i][1];
      nb[i][1] = win[i][2];
    end
    nb[0][2] = lb1[icol];
    nb[1][2] = lb0[icol];
    nb[2][2] = pin;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        v[i][j] = $signed({5'b0, nb[i][j]});
        if ((i == 0 && crow == '0) || (i == 2 && crow == Y_LAST)
         || (j == 0 && ccol == '0) || (j == 2 && ccol == X_LAST))
          v[i][j] = '0;
      end
    end
  end

  always_comb begin
    lap8 = (v[1][1] <<< 3)
         - v[0][0] - v[0][1] - v[0][2]
         - v[1][0] - v[1][2]
         - v[2][0] - v[2][1] - v[2][2];
    lap4 = (v[1][1] <<< 2)
         - v[0][1] - v[1][0] - v[1][2] - v[2][1];
    gx   = (v[0][2] + (v[1][2] <<< 1) + v[2][2])
         - (v[0][0] + (v[1][0] <<< 1) + v[2][0]);
    gy   = (v[2][0] + (v[2][1] <<< 1) + v[2][2])
         - (v[0][0] + (v[0][1] <<< 1) + v[0][2]);
    case (mode_q)
      2'd1:    mag = absv(lap4);
      2'd2:    mag = absv(gx) + absv(gy);
      default: mag = absv(lap8);
    endcase
    ebit  = CW'(mag) > CW'(thr_q);
    pk_sh = {pk, ebit};
    pk_nx = pk_sh[OP-1:0];
    word  = (pcnt == P_LAST) ? pk_nx
          : pk_nx << (OP - 1 - int'(pcnt));
  end

  always_ff @(posedge clk) begin
    if (step) begin
      lb0[icol] <= pin;
      lb1[icol] <= lb0[icol];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      mode_q     <= '0;
      thr_q      <= '0;
      nstep      <= '0;
      icol       <= '0;
      ccol       <= '0;
      crow       <= '0;
      pcnt       <= '0;
      pk         <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      frame_done <= 1'b0;
      edge_count <= '0;
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          win[i][j] <= '0;
    end else begin
      state      <= state_nx;
      frame_done <= (state == DRAIN) && out_valid && out_ready;
      if (state == IDLE && start) begin
        mode_q     <= cfg_mode;
        thr_q      <= cfg_threshold;
        nstep      <= '0;
        icol       <= '0;
        ccol       <= '0;
        crow       <= '0;
        pcnt       <= '0;
        pk         <= '0;
        edge_count <= '0;
      end
      if (step) begin
        nstep <= nstep + SW'(1);
        icol  <= (icol == X_LAST) ? '0 : icol + XW'(1);
        for (int i = 0; i < 3; i++) begin
          win[i][0] <= win[i][1];
          win[i][1] <= win[i][2];
        end
        win[0][2] <= lb1[icol];
        win[1][2] <= lb0[icol];
        win[2][2] <= pin;
        if (produce) begin
          edge_count <= edge_count + 32'(ebit);
          if (ccol == X_LAST) begin
            ccol <= '0;
            crow <= crow + YW'(1);
          end else begin
            ccol <= ccol + XW'(1);
          end
          if (load) begin
            pk   <= '0;
            pcnt <= '0;
          end else begin
            pk   <= pk_nx;
            pcnt <= pcnt + PW'(1);
          end
        end
      end
      if (load) begin
        out_data  <= word;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_edge_filter_stream.sv
// tb_edge_filter_stream: scoreboard bench for edge_filter_stream
// (8x4 frames, 8-bit pixels, 8-bit packing).
module tb_edge_filter_stream;

  localparam int W    = 8;
  localparam int H    = 4;
  localparam int PB   = 8;
  localparam int OP   = 8;
  localparam int NPIX = W * H;
  localparam int NW   = (NPIX + OP - 1) / OP;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    cfg_mode = '0;
  logic [15:0]   cfg_threshold = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [PB-1:0] in_pixel = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [OP-1:0] out_data;
  logic          busy;
  logic          frame_done;
  logic [31:0]   edge_count;

  edge_filter_stream #(
    .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H),
    .PIXEL_BITS(PB), .OUT_PACK(OP)
  ) dut (
    .clk(clk), .resetn(resetn), .start(start),
    .cfg_mode(cfg_mode), .cfg_threshold(cfg_threshold),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pixel(in_pixel), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .frame_done(frame_done),
    .edge_count(edge_count)
  );

  always #5 clk = ~clk;

  int            total = 0;
  int            bad = 0;
  logic [OP-1:0] expq[$];
  logic [OP-1:0] got[$];
  int            pix[NPIX];
  int            nfd = 0;
  int            nwords = 0;
  int            cyc = 0;
  int            stall_from = -1;
  int            stall_len = 0;
  bit            force_low = 1'b0;
  int            fd_base, w_base, wb, expcnt;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  function automatic int px(int r, int c);
    if (r < 0 || r >= H || c < 0 || c >= W) return 0;
    return pix[r*W + c];
  endfunction

  function automatic int iabs(int a);
    return (a < 0) ? -a : a;
  endfunction

  function automatic int model(int mode, int thr);
    int cnt = 0;
    int nb = 0;
    int m, a, gx, gy;
    bit e;
    logic [OP-1:0] wd = '0;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        if (mode == 1) begin
          a = 4*px(r,c) - px(r-1,c) - px(r,c-1)
            - px(r,c+1) - px(r+1,c);
          m = iabs(a);
        end else if (mode == 2) begin
          gx = px(r-1,c+1) + 2*px(r,c+1) + px(r+1,c+1)
             - px(r-1,c-1) - 2*px(r,c-1) - px(r+1,c-1);
          gy = px(r+1,c-1) + 2*px(r+1,c) + px(r+1,c+1)
             - px(r-1,c-1) - 2*px(r-1,c) - px(r-1,c+1);
          m = iabs(gx) + iabs(gy);
        end else begin
          a = 9*px(r,c);
          for (int dr = -1; dr <= 1; dr++)
            for (int dc = -1; dc <= 1; dc++)
              a -= px(r+dr, c+dc);
          m = iabs(a);
        end
        e = (m > thr);
        cnt += int'(e);
        wd = {wd[OP-2:0], e};
        nb++;
        if (nb == OP) begin
          expq.push_back(wd);
          nb = 0;
          wd = '0;
        end
      end
    end
    if (nb > 0) expq.push_back(wd << (OP - nb));
    return cnt;
  endfunction

  // Sink: scoreboard pops on every accepted word.
  logic          stalled = 1'b0;
  logic [OP-1:0] held;
  always @(negedge clk) begin
    if (!resetn) begin
      stalled = 1'b0;
    end else begin
      if (stalled) check("hold", out_data, held);
      if (out_valid && !out_ready)
        check("rdy_stall", in_ready, 0);
      stalled = out_valid && !out_ready;
      held = out_data;
      if (out_valid && out_ready) begin
        nwords++;
        got.push_back(out_data);
        check("word_expected", 32'(expq.size() > 0), 1);
        if (expq.size() > 0)
          check("word", out_data, expq.pop_front());
      end
      if (frame_done) nfd++;
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    cyc++;
    out_ready = !(force_low ||
      (cyc >= stall_from && cyc < stall_from + stall_len));
  end

  task automatic start_frame(int mode, int thr);
    expcnt = model(mode, thr);
    fd_base = nfd;
    w_base = nwords;
    wb = got.size();
    cfg_mode = 2'(mode);
    cfg_threshold = 16'(thr);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cfg_mode = ~2'(mode);
    cfg_threshold = ~16'(thr);
    check("busy_start", busy, 1);
    check("cnt_clear", edge_count, 0);
  endtask

  task automatic feed(int n, bit gap, bit poke);
    int t;
    bit hs;
    for (int i = 0; i < n; i++) begin
      if (gap)
        while ($urandom_range(0, 3) == 0) begin
          in_valid = 1'b0;
          @(posedge clk);
          #1;
        end
      in_valid = 1'b1;
      in_pixel = PB'(pix[i]);
      if (poke && i == 10) start = 1'b1;
      t = 0;
      do begin
        @(negedge clk);
        hs = in_ready;
        @(posedge clk);
        #1;
        t++;
      end while (!hs && t < 500);
      start = 1'b0;
      if (!hs) begin
        check("in_timeout", hs, 1);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic finish_frame();
    int t = 0;
    while (nfd == fd_base && t < 3000) begin
      @(posedge clk);
      t++;
    end
    repeat (3) @(posedge clk);
    #1;
    check("frame_done_n", nfd - fd_base, 1);
    check("edge_count", edge_count, expcnt);
    check("word_n", nwords - w_base, NW);
    check("q_empty", expq.size(), 0);
    check("idle", busy, 0);
  endtask

  task automatic run(int mode, int thr, bit gap, bit poke);
    start_frame(mode, thr);
    feed(NPIX, gap, poke);
    finish_frame();
  endtask

  task automatic fill(int val);
    for (int i = 0; i < NPIX; i++) pix[i] = val;
  endtask

  task automatic scen1();
    fill(100);
    run(0, 0, 0, 0);
    check("s1_w0", got[wb+0], 8'hFF);
    check("s1_w1", got[wb+1], 8'h81);
    check("s1_w2", got[wb+2], 8'h81);
    check("s1_w3", got[wb+3], 8'hFF);
    check("s1_cnt", edge_count, 20);
    run(0, 400, 0, 0);
    check("s1b_w1", got[wb+1], 8'h00);
    check("s1b_cnt", edge_count, 4);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_edge_count", edge_count, 0);
    resetn = 1'b1;
    @(posedge clk);
    #1;

    scen1();

    fill(100);
    run(1, 0, 0, 0);
    run(1, 150, 0, 0);
    check("s2_w0", got[wb+0], 8'h81);

    fill(0);
    pix[1*W + 3] = 255;
    run(0, 0, 0, 0);
    check("s3_cnt", edge_count, 9);
    run(2, 0, 0, 0);
    check("s3_w1", got[wb+1], 8'h28);
    check("s3b_cnt", edge_count, 8);

    fill(0);
    for (int r = 0; r < H; r++)
      for (int c = 4; c < 7; c++)
        pix[r*W + c] = $urandom_range(0, 255);
    pix[1*W + 7] = 255;
    pix[2*W + 7] = 255;
    run(0, 0, 0, 0);
    for (int r = 0; r < H; r++)
      check("s4_col0", got[wb+r][OP-1], 0);

    for (int i = 0; i < NPIX; i++) pix[i] = $urandom_range(0, 255);
    stall_from = cyc + 25;
    stall_len = 50;
    run(2, 200, 1, 1);
    for (int i = 0; i < NPIX; i++) pix[i] = $urandom_range(0, 255);
    run(1, 90, 1, 0);

    fill(100);
    force_low = 1'b1;
    start_frame(0, 0);
    feed(17, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    check("s6_valid", out_valid, 1);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("s6_busy", busy, 1);
    @(negedge clk);
    resetn = 1'b0;
    #1;
    check("s6_rst_valid", out_valid, 0);
    check("s6_rst_busy", busy, 0);
    check("s6_rst_ready", in_ready, 0);
    check("s6_rst_cnt", edge_count, 0);
    expq.delete();
    force_low = 1'b0;
    @(posedge clk);
    #1;
    resetn = 1'b1;
    @(posedge clk);
    #1;
    scen1();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/edge_filter_stream.md
Name: edge_filter_stream

Overview:
Parametrised streaming 3x3 edge detector. It is the next generation of the PCPI Laplacian edge path.
- Input: raster-order grayscale pixels over a valid/ready stream, e.g. from the JPEG reorder buffer.
- Output: packed 1-bit edge maps over valid/ready, to the frame buffer or UART feeder.
- New relative to the previous generation: selectable kernel (Laplacian-8, Laplacian-4, Sobel), generic pixel width and packing, true column-border zero padding with no row wrap, backpressure, and a per-frame edge count.

Parameters:
IMAGE_WIDTH, 320, pixels per row (>=3)
IMAGE_HEIGHT, 240, rows per frame (>=2)
PIXEL_BITS, 8, input pixel width (1..12)
OUT_PACK, 8, edge bits per output word (1..32)

Ports:
clk  in  1  clock
resetn  in  1  reset, asynchronous, active-low
start  in  1  one-cycle pulse; begins a frame when idle
cfg_mode  in  2  0=Laplacian-8, 1=Laplacian-4, 2=Sobel, 3=treated as 0
cfg_threshold  in  16  edge threshold
in_valid  in  1  input pixel valid
in_ready  out  1  input pixel accepted when in_valid&&in_ready
in_pixel  in  PIXEL_BITS  grayscale pixel, raster order
out_valid  out  1  packed word valid
out_ready  in  1  sink accepts word
out_data  out  OUT_PACK  packed edge bits; first pixel at bit OUT_PACK-1
busy  out  1  frame in progress
frame_done  out  1  one-cycle pulse after the last word is accepted
edge_count  out  32  edge pixels in the current or last frame

Behaviour:
- Reset values: in_ready=0, out_valid=0, out_data=0, busy=0, frame_done=0, edge_count=0. All state clears immediately when resetn falls, including mid-frame.
- States:
  - IDLE: start -> RUN; latch cfg_mode and cfg_threshold; clear edge_count, pixel and pack counters; busy=1.
  - RUN: consume W*H input pixels; after the last one -> FLUSH.
  - FLUSH: inject W+1 internal zero pixels without consuming input -> DRAIN.
  - DRAIN: wait until the final word is accepted; pulse frame_done; -> IDLE with busy=0.
- start while busy is ignored. cfg_* changes mid-frame are ignored.
- Step = one window advance. It occurs on an input handshake (RUN) or on an injected zero (FLUSH).
  - A step is permitted only when (!out_valid || out_ready).
  - in_ready = (state==RUN) && (!out_valid || out_ready).
- Window: two line buffers of IMAGE_WIDTH x PIXEL_BITS plus a 3x3 register array.
  - The step that shifts in pixel (r+1,c+1) evaluates the centre (r,c).
  - The first W+1 steps of a frame produce no edge bit.
  - Total steps = W*H+W+1. Edge bits produced = W*H.
- Padding: neighbours outside the image read as 0.
  - Applies to rows -1 and H, and to columns -1 and W.
  - Columns are masked by centre column: no wrap to the adjacent row.
- Arithmetic: signed, PIXEL_BITS+5 bits; magnitude is PIXEL_BITS+4 bits.
  - Mode 0: 8*cc minus the sum of the 8 neighbours, then absolute value.
  - Mode 1: 4*cc - tc - cl - cr - bc, then absolute value.
  - Mode 2: gx = (tr+2cr+br)-(tl+2cl+bl); gy = (bl+2bc+br)-(tl+2tc+tr); mag = |gx|+|gy|.
  - edge = mag > threshold. Comparison is strict, with both operands zero-extended to a common width.
- Packing:
  - Each edge bit shifts into the LSB of the pack register (left shift), so the first pixel lands at the MSB.
  - After OUT_PACK bits, the word loads into the output register with out_valid=1, one cycle after the completing step.
  - If W*H mod OUT_PACK != 0, the final partial word is left-aligned and padded with 0 LSBs at the end of FLUSH.
- out_data is held stable while out_valid && !out_ready.
- edge_count increments per edge bit; it holds after frame_done until the next start.

Test Plan:
1. W=8, H=4, all pixels 100, mode 0, threshold 0 -> words 0xFF, 0x81, 0x81, 0xFF; edge_count=20; one frame_done. Threshold 400 -> 0x81, 0x00, 0x00, 0x81; count 4.
2. Same frame, mode 1: threshold 0 -> 0xFF, 0x81, 0x81, 0xFF. Threshold 150 -> 0x81, 0x00, 0x00, 0x81 (corner 200, side 100).
3. Zero frame (W=8, H=4) with 255 at (1,3), threshold 0: mode 0 -> 0x38, 0x38, 0x38, 0x00, count 9; mode 2 -> 0x38, 0x28, 0x38, 0x00, count 8.
4. Column-wrap check: W=8, H=4 random frame with a bright pixel at column 7 -> no edge bit set in column 0 of the neighbouring rows.
5. out_ready held low 50 cycles mid-frame, with random in_valid gaps -> in_ready=0 while stalled; out_data stable; no lost or duplicated words; final words match the golden model; exactly W*H/OUT_PACK words.
6. resetn pulsed low mid-RUN -> out_valid, busy and in_ready drop to 0 in the same cycle. A start issued during a frame is ignored. A fresh frame after reset matches scenario 1.
